package_arbiter: RTL and testbench

Round-robin scheduler that shares one downstream package sink between N_CH serial-decoder channels. Each `assembly` instance presents a 28-bit package with a one-cycle `o_ready` strobe. This block captures each package into a per-channel holding register and grants the single output port in round-robin order under a valid/accept handshake. It sits between the bank of `assembly` decoders and the package consumer (FIFO/host interface), and reports dropped packages per channel.

---
 rtl/pkg_arb_pkg.sv | 28 ++
 rtl/pkg_arb_slot.sv | 42 ++++
 rtl/package_arbiter.sv | 120 ++++++++++++
 tb/tb_package_arbiter.sv | 264 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/pkg_arb_pkg.sv
// Shared constants, channel-width helper and channel-slot layout for package_arbiter.
// Latency: none (declarations only).
// Backpressure: none. PKG_ARB_TIMESTAMP_EN adds the stamp field to the slot layout.
package pkg_arb_pkg;

    // Package width produced by the assembly decoder.
    localparam int PKG_W_DEF = 28;

    // Width of the free-running capture timestamp.
    localparam int STAMP_W = 16;

    typedef logic [STAMP_W-1:0] stamp_t;

    // Channel index width, never narrower than one bit.
    function automatic int ch_w(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

    // Contents of one channel holding register. The package field is laid out
    // at the decoder width; the top converts to its own PKG_W at the ports.
    typedef struct packed {
        logic [PKG_W_DEF-1:0] pkg;
`ifdef PKG_ARB_TIMESTAMP_EN
        stamp_t               stamp;
`endif
    } slot_t;

endpackage

// File: rtl/pkg_arb_slot.sv
// One channel's holding register, pending flag and sticky overflow flag.
// Latency: a capture strobe sets pend on the next rising edge.
// Backpressure: a capture while held and not granted is dropped and flagged.
module pkg_arb_slot
    import pkg_arb_pkg::*;
(
    input  logic  clk,
    input  logic  rst,
    input  logic  cap,
    input  logic  grant,
    input  logic  ovf_clr,
    input  slot_t din,
    output logic  pend,
    output slot_t dat,
    output logic  ovf
);

    // Hold register: refill is allowed in the same cycle the old contents are granted.
    always_ff @(posedge clk) begin
        if (rst) begin
            pend <= 1'b0;
            dat  <= '0;
        end else if (cap && (!pend || grant)) begin
            dat  <= din;
            pend <= 1'b1;
        end else if (grant) begin
            pend <= 1'b0;
        end
    end

    // Sticky overflow: a new package arriving on top of an ungranted one; set beats clear.
    always_ff @(posedge clk) begin
        if (rst) begin
            ovf <= 1'b0;
        end else if (cap && pend && !grant) begin
            ovf <= 1'b1;
        end else if (ovf_clr) begin
            ovf <= 1'b0;
        end
    end

endmodule

// File: rtl/package_arbiter.sv
// Round-robin share of one package sink between N_CH decoder channels (PKG_ARB_TIMESTAMP_EN adds o_stamp).
// Latency: i_ready at cycle t gives o_valid from cycle t+2 when the output stage is free.
// Backpressure: o_valid/o_pkg held until i_accept; refused captures set sticky o_ovf.
module package_arbiter
    import pkg_arb_pkg::*;
#(
    parameter  int N_CH  = 4,
    parameter  int PKG_W = PKG_W_DEF,
    localparam int CH_W  = ch_w(N_CH)
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic                  i_ena,
    input  logic [N_CH*PKG_W-1:0] i_pkg,
    input  logic [N_CH-1:0]       i_ready,
    input  logic                  i_accept,
    output logic [PKG_W-1:0]      o_pkg,
    output logic [CH_W-1:0]       o_ch,
    output logic                  o_valid,
    output logic [N_CH-1:0]       o_ovf,
    input  logic                  i_ovf_clr
`ifdef PKG_ARB_TIMESTAMP_EN
    ,
    output logic [STAMP_W-1:0]    o_stamp
`endif
);

    logic [N_CH-1:0] pend;
    logic [N_CH-1:0] grant;
    slot_t           slot_dat [N_CH];
    logic            free;
    logic            found;
    logic [CH_W-1:0] win;
    logic [CH_W-1:0] cand;
    logic [CH_W-1:0] last;

`ifdef PKG_ARB_TIMESTAMP_EN
    stamp_t cnt;

    // Free-running cycle counter, wraps naturally at 0xFFFF.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end
`endif

    for (genvar k = 0; k < N_CH; k++) begin : g_slot
        slot_t din;

        assign din.pkg   = PKG_W_DEF'(i_pkg[k*PKG_W +: PKG_W]);
`ifdef PKG_ARB_TIMESTAMP_EN
        assign din.stamp = cnt;
`endif

        pkg_arb_slot u_slot (
            .clk     (i_clk),
            .rst     (i_rst),
            .cap     (i_ena & i_ready[k]),
            .grant   (grant[k]),
            .ovf_clr (i_ovf_clr),
            .din     (din),
            .pend    (pend[k]),
            .dat     (slot_dat[k]),
            .ovf     (o_ovf[k])
        );
    end

    assign free = !o_valid || i_accept;

    // Round-robin search starting one past the last winner, wrapping modulo N_CH.
    always_comb begin
        found = 1'b0;
        win   = '0;
        cand  = '0;
        for (int i = 1; i <= N_CH; i++) begin
            cand = CH_W'((int'(last) + i) % N_CH);
            if (!found && pend[cand]) begin
                found = 1'b1;
                win   = cand;
            end
        end
    end

    // One-hot grant back to the slots, only when the output stage can take it.
    always_comb begin
        grant = '0;
        if (free && found) begin
            grant[win] = 1'b1;
        end
    end

    // Output stage: load the winner when free, drop valid when free and idle.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            o_valid <= 1'b0;
            o_pkg   <= '0;
            o_ch    <= '0;
            last    <= CH_W'(N_CH - 1);
`ifdef PKG_ARB_TIMESTAMP_EN
            o_stamp <= '0;
`endif
        end else if (free) begin
            if (found) begin
                o_valid <= 1'b1;
                o_pkg   <= PKG_W'(slot_dat[win].pkg);
                o_ch    <= win;
                last    <= win;
`ifdef PKG_ARB_TIMESTAMP_EN
                o_stamp <= slot_dat[win].stamp;
`endif
            end else begin
                o_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_package_arbiter.sv
module tb_package_arbiter;

    localparam int N_CH  = 4;
    localparam int PKG_W = 28;
    localparam int CH_W  = 2;

    logic                  i_clk = 1'b0;
    logic                  i_rst;
    logic                  i_ena;
    logic [N_CH*PKG_W-1:0] i_pkg;
    logic [N_CH-1:0]       i_ready;
    logic                  i_accept;
    logic                  i_ovf_clr;
    logic [PKG_W-1:0]      o_pkg;
    logic [CH_W-1:0]       o_ch;
    logic                  o_valid;
    logic [N_CH-1:0]       o_ovf;
`ifdef PKG_ARB_TIMESTAMP_EN
    logic [15:0]           o_stamp;
`endif

    int errors = 0;
    int checks = 0;

    // Expected deliveries in order: {channel, package}.
    logic [CH_W+PKG_W-1:0] sb [$];

    always #5 i_clk = ~i_clk;

    package_arbiter #(.N_CH(N_CH), .PKG_W(PKG_W)) dut (
        .i_clk     (i_clk),
        .i_rst     (i_rst),
        .i_ena     (i_ena),
        .i_pkg     (i_pkg),
        .i_ready   (i_ready),
        .i_accept  (i_accept),
        .o_pkg     (o_pkg),
        .o_ch      (o_ch),
        .o_valid   (o_valid),
        .o_ovf     (o_ovf),
        .i_ovf_clr (i_ovf_clr)
`ifdef PKG_ARB_TIMESTAMP_EN
        ,
        .o_stamp   (o_stamp)
`endif
    );

    // Scoreboard: every accepted transfer must match the next expected package.
    always @(negedge i_clk) begin
        if (!i_rst && o_valid && i_accept) begin
            logic [CH_W+PKG_W-1:0] exp_v;
            checks++;
            if (sb.size() == 0) begin
                errors++;
                $display("FAIL sb_unexpected: got ch=%0d pkg=%h, required no delivery", o_ch, o_pkg);
            end else begin
                exp_v = sb.pop_front();
                if ({o_ch, o_pkg} !== exp_v) begin
                    errors++;
                    $display("FAIL sb_order: got ch=%0d pkg=%h, required ch=%0d pkg=%h",
                             o_ch, o_pkg, exp_v[CH_W+PKG_W-1:PKG_W], exp_v[PKG_W-1:0]);
                end
            end
        end
    end

    // Advance to just after the next rising edge; strobes last one cycle.
    task automatic step;
        @(posedge i_clk);
        #1;
        i_ready   = '0;
        i_ovf_clr = 1'b0;
    endtask

    task automatic drive(input int ch, input logic [PKG_W-1:0] p);
        i_ready[ch]             = 1'b1;
        i_pkg[ch*PKG_W +: PKG_W] = p;
    endtask

    task automatic expect_pkg(input int ch, input logic [PKG_W-1:0] p);
        sb.push_back({CH_W'(ch), p});
    endtask

    task automatic do_reset;
        i_rst = 1'b1;
        step;
        i_rst = 1'b0;
    endtask

    task automatic test_reset;
        i_rst = 1'b1; i_ena = 1'b1; i_accept = 1'b0; i_ovf_clr = 1'b0;
        i_ready = '0; i_pkg = '0;
        repeat (2) @(posedge i_clk);
        @(negedge i_clk);
        checks++; if (o_valid !== 1'b0) begin errors++; $display("FAIL rst_valid: got %b, required 0", o_valid); end
        checks++; if (o_pkg !== '0) begin errors++; $display("FAIL rst_pkg: got %h, required 0", o_pkg); end
        checks++; if (o_ch !== '0) begin errors++; $display("FAIL rst_ch: got %0d, required 0", o_ch); end
        checks++; if (o_ovf !== '0) begin errors++; $display("FAIL rst_ovf: got %b, required 0000", o_ovf); end
        step;
        i_rst = 1'b0;
    endtask

    task automatic test_single;
        i_accept = 1'b1;
        drive(2, 28'h0ABCDEF); expect_pkg(2, 28'h0ABCDEF);
        step; @(negedge i_clk);
        checks++; if (o_valid !== 1'b0) begin errors++; $display("FAIL single_early: got valid=%b, required 0", o_valid); end
        step; @(negedge i_clk);
        checks++;
        if (o_valid !== 1'b1 || o_pkg !== 28'h0ABCDEF || o_ch !== 2'd2) begin
            errors++; $display("FAIL single_out: got valid=%b pkg=%h ch=%0d, required 1 0abcdef 2", o_valid, o_pkg, o_ch);
        end
        step; @(negedge i_clk);
        checks++; if (o_valid !== 1'b0) begin errors++; $display("FAIL single_drop: got valid=%b, required 0", o_valid); end
    endtask

    task automatic test_simultaneous;
        do_reset;
        i_accept = 1'b1;
        for (int k = 0; k < N_CH; k++) begin
            drive(k, 28'h0800000 + 28'(k));
            expect_pkg(k, 28'h0800000 + 28'(k));
        end
        step;
        for (int k = 0; k < N_CH; k++) begin
            step; @(negedge i_clk);
            checks++;
            if (o_valid !== 1'b1 || o_ch !== CH_W'(k)) begin
                errors++; $display("FAIL simul_grant%0d: got valid=%b ch=%0d, required 1 %0d", k, o_valid, o_ch, k);
            end
        end
        step; @(negedge i_clk);
        checks++; if (o_valid !== 1'b0) begin errors++; $display("FAIL simul_idle: got valid=%b, required 0", o_valid); end
    endtask

    task automatic test_fairness;
        do_reset;
        i_accept = 1'b1;
        drive(1, 28'h0111111); expect_pkg(1, 28'h0111111);
        step;
        drive(0, 28'h0000AAA); drive(3, 28'h0333BBB);
        expect_pkg(3, 28'h0333BBB); expect_pkg(0, 28'h0000AAA);
        step; step; @(negedge i_clk);
        checks++; if (o_ch !== 2'd3) begin errors++; $display("FAIL fair_first: got ch=%0d, required 3", o_ch); end
        step; @(negedge i_clk);
        checks++; if (o_ch !== 2'd0) begin errors++; $display("FAIL fair_second: got ch=%0d, required 0", o_ch); end
        step;
    endtask

    task automatic test_backpressure;
        do_reset;
        i_accept = 1'b0;
        drive(0, 28'h0A0A0A0); expect_pkg(0, 28'h0A0A0A0);
        step;
        drive(1, 28'h0B1B1B1); expect_pkg(1, 28'h0B1B1B1);
        step;
        drive(1, 28'h0B2B2B2);
        step; @(negedge i_clk);
        checks++;
        if (o_valid !== 1'b1 || o_pkg !== 28'h0A0A0A0 || o_ch !== 2'd0) begin
            errors++; $display("FAIL bp_hold: got valid=%b pkg=%h ch=%0d, required 1 0a0a0a0 0", o_valid, o_pkg, o_ch);
        end
        checks++; if (o_ovf !== 4'b0010) begin errors++; $display("FAIL bp_ovf: got %b, required 0010", o_ovf); end
        repeat (3) step;
        @(negedge i_clk);
        checks++; if (o_pkg !== 28'h0A0A0A0) begin errors++; $display("FAIL bp_stable: got %h, required 0a0a0a0", o_pkg); end
        i_accept = 1'b1;
        step; @(negedge i_clk);
        checks++; if (o_pkg !== 28'h0B1B1B1) begin errors++; $display("FAIL bp_first_kept: got %h, required 0b1b1b1", o_pkg); end
        step;
        i_ovf_clr = 1'b1;
        step; @(negedge i_clk);
        checks++; if (o_ovf !== 4'b0000) begin errors++; $display("FAIL bp_clr: got %b, required 0000", o_ovf); end
        // Overflow and clear in the same cycle: the set must survive.
        i_accept = 1'b0;
        drive(0, 28'h0E0E0E0); expect_pkg(0, 28'h0E0E0E0);
        step;
        drive(1, 28'h0F1F1F1); expect_pkg(1, 28'h0F1F1F1);
        step;
        drive(1, 28'h0F2F2F2); i_ovf_clr = 1'b1;
        step; @(negedge i_clk);
        checks++; if (o_ovf !== 4'b0010) begin errors++; $display("FAIL bp_set_wins: got %b, required 0010", o_ovf); end
        i_accept = 1'b1;
        repeat (3) step;
        i_ovf_clr = 1'b1;
        step;
    endtask

    task automatic test_cap_grant_ena;
        do_reset;
        i_accept = 1'b1;
        drive(0, 28'h0C0C0C0); expect_pkg(0, 28'h0C0C0C0);
        step;
        drive(0, 28'h0C1C1C1); expect_pkg(0, 28'h0C1C1C1);
        step;
        i_ena = 1'b0;
        drive(3, 28'h0D3D3D3);
        step;
        i_ena = 1'b1;
        repeat (3) step;
        @(negedge i_clk);
        checks++; if (o_valid !== 1'b0) begin errors++; $display("FAIL cg_idle: got valid=%b, required 0", o_valid); end
        checks++; if (o_ovf !== 4'b0000) begin errors++; $display("FAIL cg_ovf: got %b, required 0000", o_ovf); end
    endtask

    task automatic test_mid_reset;
        i_accept = 1'b0;
        drive(2, 28'h0262626);
        step;
        drive(1, 28'h0161616);
        step; @(negedge i_clk);
        checks++; if (o_valid !== 1'b1) begin errors++; $display("FAIL mr_pre: got valid=%b, required 1", o_valid); end
        i_rst = 1'b1;
        drive(1, 28'h0171717);
        step;
        i_rst = 1'b0;
        @(negedge i_clk);
        checks++; if (o_valid !== 1'b0) begin errors++; $display("FAIL mr_valid: got %b, required 0", o_valid); end
        checks++; if (o_ovf !== 4'b0000) begin errors++; $display("FAIL mr_ovf: got %b, required 0000", o_ovf); end
        i_accept = 1'b1;
        drive(3, 28'h0393939); expect_pkg(3, 28'h0393939);
        repeat (5) step;
    endtask

`ifdef PKG_ARB_TIMESTAMP_EN
    task automatic test_timestamp;
        do_reset;
        i_accept = 1'b1;
        repeat (16) step;
        drive(1, 28'h0515151); expect_pkg(1, 28'h0515151);
        step; step; @(negedge i_clk);
        checks++; if (o_stamp !== 16'h0010) begin errors++; $display("FAIL ts_value: got %h, required 0010", o_stamp); end
        repeat (65535 - 18) step;
        drive(2, 28'h0525252); expect_pkg(2, 28'h0525252);
        step;
        drive(3, 28'h0535353); expect_pkg(3, 28'h0535353);
        step; @(negedge i_clk);
        checks++; if (o_stamp !== 16'hFFFF) begin errors++; $display("FAIL ts_top: got %h, required ffff", o_stamp); end
        step; @(negedge i_clk);
        checks++; if (o_stamp !== 16'h0000) begin errors++; $display("FAIL ts_wrap: got %h, required 0000", o_stamp); end
        step;
    endtask
`endif

    initial begin
        test_reset;
        test_single;
        test_simultaneous;
        test_fairness;
        test_backpressure;
        test_cap_grant_ena;
        test_mid_reset;
`ifdef PKG_ARB_TIMESTAMP_EN
        test_timestamp;
`endif
        checks++;
        if (sb.size() != 0) begin
            errors++; $display("FAIL sb_drained: got %0d outstanding, required 0", sb.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
